// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one uart_send transmitter between N_REQ byte producers; define UART_SCHED_PRIO0_EN to give requester 0 strict priority
module uart_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int IDW     = 3,
  parameter int BUSY_TO = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               uart_en_o,
  output logic [7:0]         uart_din_o,
  input  logic               uart_busy_i,
  output logic [IDW-1:0]     grant_id_o,
  output logic               sched_busy_o,
  output logic               err_o
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gid_q, gid_d, g, g_next;
  logic [7:0] din_q, din_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2*N_REQ-1:0] rot;
  always_comb begin
    g = '0;
    rot = {req_valid_i, req_valid_i} >> rr_ptr_q;
    for (int k = N_REQ-1; k >= 0; k--)
      if (rot[k]) g = IDW'((int'(rr_ptr_q) + k) % N_REQ);
`ifdef UART_SCHED_PRIO0_EN
    if (req_valid_i[0]) g = '0;
`endif
    g_next = (int'(g) == N_REQ-1) ? '0 : g + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d = gid_q;
    din_d = din_q;
    cnt_d = cnt_q;
    req_ready_o = '0;
    uart_en_o = 1'b0;
    err_o = 1'b0;
    case (state_q)
      IDLE: if (|req_valid_i && !uart_busy_i) begin
        req_ready_o = N_REQ'(1) << g;
        din_d = 8'(req_data_i >> {g, 3'd0});
        gid_d = g;
`ifdef UART_SCHED_PRIO0_EN
        rr_ptr_d = req_valid_i[0] ? rr_ptr_q : g_next;
`else
        rr_ptr_d = g_next;
`endif
        state_d = LAUNCH;
      end
      LAUNCH: begin
        uart_en_o = 1'b1;
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (uart_busy_i) state_d = WAIT_DONE;
        else if (int'(cnt_q) == BUSY_TO-1) begin
          err_o = 1'b1;
          state_d = IDLE;
        end
        else cnt_d = cnt_q + 1'b1;
      default: if (!uart_busy_i) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gid_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q <= gid_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
    end
  assign uart_din_o = din_q;
  assign grant_id_o = gid_q;
  assign sched_busy_o = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized self-checking bench for uart_tx_sched against a cycle-arithmetic reference model
module tb_uart_tx_sched;
  localparam int N = 4, IDW = 3, BTO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic uart_en, uart_busy, sched_busy, err;
  logic [7:0] uart_din;
  logic [IDW-1:0] grant_id;
  logic tx_on = 1'b1, force_busy = 1'b0;
  logic [3:0] tx_left = '0;
  int tx_len = 3;
  int n_chk = 0, n_err = 0, cyc = 0, errs = 0;
  int m_ptr = 0, free_at = 0, launch_at = -1, err_at = -1, m_gid = 0;
  logic [7:0] m_din = '0;
  int grants[$];
  logic [7:0] sent[$];
  always #5 clk = ~clk;
  uart_tx_sched #(.N_REQ(N), .IDW(IDW), .BUSY_TO(BTO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .uart_en_o(uart_en), .uart_din_o(uart_din),
    .uart_busy_i(uart_busy), .grant_id_o(grant_id), .sched_busy_o(sched_busy), .err_o(err)
  );
  assign uart_busy = force_busy | (tx_on & uart_en) | (tx_left != 0);
  always @(posedge clk)
    tx_left <= (uart_en && tx_on) ? 4'(tx_len) : (tx_left != 0 ? tx_left - 4'd1 : 4'd0);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v);
`ifdef UART_SCHED_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
  always @(negedge clk) begin
    int g;
    logic go;
    cyc++;
    if (rst) begin
      m_ptr = 0;
      free_at = 0;
      launch_at = -1;
      err_at = -1;
      m_din = '0;
      m_gid = 0;
    end else begin
      go = cyc >= free_at && |req_valid && !uart_busy;
      g = pick(req_valid);
      if (err) errs++;
      check("ready", 32'(req_ready), go ? 32'(1) << g : 32'(0));
      check("uart_en", 32'(uart_en), 32'(cyc == launch_at));
      check("err", 32'(err), 32'(cyc == err_at));
      check("sched_busy", 32'(sched_busy), 32'(cyc < free_at));
      check("din", 32'(uart_din), 32'(m_din));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      if (cyc == launch_at + 2) sent.push_back(uart_din);
      if (cyc == launch_at) begin
        if (tx_on) free_at = cyc + 2 + tx_len;
        else begin
          err_at = cyc + BTO;
          free_at = err_at + 1;
        end
      end
      if (go) begin
        grants.push_back(g);
        m_din = 8'(req_data >> (8 * g));
        m_gid = g;
        launch_at = cyc + 1;
        free_at = cyc + 1000;
`ifdef UART_SCHED_PRIO0_EN
        if (!req_valid[0]) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask
  task automatic wait_grants(input int n, input string tag);
    int target = grants.size() + n;
    int t = 0;
    while (grants.size() < target && t < 400) begin
      step();
      t++;
    end
    check({tag, "_grant_wait"}, 32'(grants.size() >= target), 32'(1));
  endtask
  task automatic drain(input string tag);
    int t = 0;
    req_valid = '0;
    force_busy = 1'b0;
    step();
    while ((sched_busy || tx_left != 0) && t < 400) begin
      step();
      t++;
    end
    check({tag, "_drain"}, 32'(sched_busy || tx_left != 0), 32'(0));
  endtask
  initial begin
    int base, e0;
    do_reset();
    req_data = 32'h0000_A500;
    req_valid = 4'b0010;
    wait_grants(1, "single");
    drain("single");
    check("single_id", 32'(grants[$]), 32'(1));
    check("single_byte", 32'(sent[$]), 32'hA5);
    do_reset();
    base = grants.size();
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    wait_grants(5, "all");
    drain("all");
    for (int i = 0; i < 5; i++)
`ifdef UART_SCHED_PRIO0_EN
      check("rr_order", 32'(grants[base + i]), 32'(0));
`else
      check("rr_order", 32'(grants[base + i]), 32'(i % N));
`endif
    e0 = errs;
    tx_on = 1'b0;
    req_valid = 4'b0001;
    wait_grants(1, "timeout");
    drain("timeout");
    check("timeout_err_count", 32'(errs - e0), 32'(1));
    tx_on = 1'b1;
    req_valid = 4'b0100;
    wait_grants(1, "post_timeout");
    drain("post_timeout");
    check("post_timeout_id", 32'(grants[$]), 32'(2));
    tx_len = 8;
    req_valid = 4'b0010;
    wait_grants(1, "mid");
    req_valid = '0;
    repeat (3) step();
    check("mid_frame_busy", 32'(sched_busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    wait_grants(1, "after_reset");
    drain("after_reset");
    check("after_reset_id", 32'(grants[$]), 32'(0));
    tx_len = 3;
    base = grants.size();
    force_busy = 1'b1;
    req_valid = 4'b0001;
    repeat (6) step();
    check("held_off", 32'(grants.size() - base), 32'(0));
    force_busy = 1'b0;
    wait_grants(1, "busy_release");
    drain("busy_release");
    check("busy_release_id", 32'(grants[$]), 32'(0));
    repeat (2000) begin
      step();
      req_valid = 4'($urandom) & 4'($urandom);
      req_data = $urandom;
      if (!sched_busy && tx_left == 0) begin
        tx_on = $urandom_range(0, 9) != 0;
        force_busy = $urandom_range(0, 4) == 0;
        tx_len = $urandom_range(1, 6);
      end
    end
    drain("random");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end
endmodule
